// File: rtl/pong_game_ctrl.sv
// Match sequencer for the pong datapath: walks idle/serve/play/miss/over,
// keeps score, lives and speed level, and gates ball motion.
module pong_game_ctrl #(
  parameter int LIVES          = 3,
  parameter int SERVE_FRAMES   = 60,
  parameter int MISS_FRAMES    = 30,
  parameter int HITS_PER_LEVEL = 3,
  parameter int MAX_LEVEL      = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        refresh_tick,
  input  logic        start,
  input  logic        paddle_hit,
  input  logic        ball_miss,
  output logic        ball_reset,
  output logic        ball_enable,
  output logic [3:0]  speed_level,
  output logic [15:0] score,
  output logic [1:0]  lives,
  output logic        game_over,
  output logic [2:0]  state
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SERVE = 3'd1;
  localparam logic [2:0] ST_PLAY  = 3'd2;
  localparam logic [2:0] ST_MISS  = 3'd3;
  localparam logic [2:0] ST_OVER  = 3'd4;

  localparam logic [1:0] LIVES_INIT = 2'(LIVES);
  localparam logic [7:0] SERVE_CNT  = 8'(SERVE_FRAMES);
  localparam logic [7:0] MISS_CNT   = 8'(MISS_FRAMES);
  localparam logic [3:0] HIT_LIMIT  = 4'(HITS_PER_LEVEL);
  localparam logic [3:0] LEVEL_MAX  = 4'(MAX_LEVEL);

  logic [2:0]  state_q, state_d;
  logic [15:0] score_q, score_d;
  logic [1:0]  lives_q, lives_d;
  logic [3:0]  speed_q, speed_d;
  logic [7:0]  frame_q, frame_d;
  logic [3:0]  hit_q, hit_d;
  logic        start_d_q;
  logic        ball_reset_q, ball_enable_q, game_over_q;
  logic        start_rise;

  assign start_rise = start & ~start_d_q;

  always_comb begin
    state_d = state_q;
    score_d = score_q;
    lives_d = lives_q;
    speed_d = speed_q;
    frame_d = frame_q;
    hit_d   = hit_q;
    unique case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start_rise) begin
          state_d = ST_SERVE;
          score_d = 16'd0;
          lives_d = LIVES_INIT;
          speed_d = 4'd1;
          hit_d   = 4'd0;
          frame_d = SERVE_CNT;
        end
      end
      ST_SERVE: begin
        if (refresh_tick) begin
          if (frame_q <= 8'd1) begin
            frame_d = 8'd0;
            state_d = ST_PLAY;
          end else begin
            frame_d = frame_q - 8'd1;
          end
        end
      end
      ST_PLAY: begin
        // A miss in the same cycle as a hit swallows the hit.
        if (ball_miss) begin
          state_d = ST_MISS;
          lives_d = (lives_q != 2'd0) ? lives_q - 2'd1 : 2'd0;
          frame_d = MISS_CNT;
          speed_d = 4'd1;
          hit_d   = 4'd0;
        end else if (paddle_hit) begin
          score_d = (score_q == 16'hFFFF) ? score_q : score_q + 16'd1;
          if (hit_q + 4'd1 >= HIT_LIMIT) begin
            hit_d   = 4'd0;
            speed_d = (speed_q >= LEVEL_MAX) ? LEVEL_MAX : speed_q + 4'd1;
          end else begin
            hit_d = hit_q + 4'd1;
          end
        end
      end
      ST_MISS: begin
        if (refresh_tick) begin
          if (frame_q <= 8'd1) begin
            if (lives_q == 2'd0) begin
              frame_d = 8'd0;
              state_d = ST_OVER;
            end else begin
              frame_d = SERVE_CNT;
              state_d = ST_SERVE;
            end
          end else begin
            frame_d = frame_q - 8'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      score_q       <= 16'd0;
      lives_q       <= LIVES_INIT;
      speed_q       <= 4'd1;
      frame_q       <= 8'd0;
      hit_q         <= 4'd0;
      start_d_q     <= 1'b0;
      ball_reset_q  <= 1'b1;
      ball_enable_q <= 1'b0;
      game_over_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      score_q       <= score_d;
      lives_q       <= lives_d;
      speed_q       <= speed_d;
      frame_q       <= frame_d;
      hit_q         <= hit_d;
      start_d_q     <= start;
      // Ball control flags follow the state being entered, so they line up with it.
      ball_reset_q  <= (state_d != ST_PLAY);
      ball_enable_q <= (state_d == ST_PLAY);
      game_over_q   <= (state_d == ST_OVER);
    end
  end

  assign ball_reset  = ball_reset_q;
  assign ball_enable = ball_enable_q;
  assign speed_level = speed_q;
  assign score       = score_q;
  assign lives       = lives_q;
  assign game_over   = game_over_q;
  assign state       = state_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Scoreboard bench for pong_game_ctrl: directed stimulus queues expected
// snapshots, a negedge monitor pops and compares them against the outputs.
module tb_pong_game_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        refresh_tick = 1'b0;
  logic        start = 1'b0;
  logic        paddle_hit = 1'b0;
  logic        ball_miss = 1'b0;
  logic        ball_reset, ball_enable, game_over;
  logic [3:0]  speed_level;
  logic [15:0] score;
  logic [1:0]  lives;
  logic [2:0]  state;

  pong_game_ctrl #(
    .LIVES(3), .SERVE_FRAMES(60), .MISS_FRAMES(30),
    .HITS_PER_LEVEL(3), .MAX_LEVEL(8)
  ) dut (
    .clk(clk), .reset(reset), .refresh_tick(refresh_tick), .start(start),
    .paddle_hit(paddle_hit), .ball_miss(ball_miss),
    .ball_reset(ball_reset), .ball_enable(ball_enable),
    .speed_level(speed_level), .score(score), .lives(lives),
    .game_over(game_over), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  st;
    logic [15:0] sc;
    logic [1:0]  lv;
    logic [3:0]  sp;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    compared = 0;
  int    mismatched = 0;

  task automatic expect_out(input string nm, input logic [2:0] st,
                            input logic [15:0] sc, input logic [1:0] lv,
                            input logic [3:0] sp);
    exp_t e;
    e.st = st; e.sc = sc; e.lv = lv; e.sp = sp;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: compares one queued snapshot per falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      string nm;
      logic  br, be, go;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      br = (e.st != 3'd2);
      be = (e.st == 3'd2);
      go = (e.st == 3'd4);
      compared++;
      if (state !== e.st || score !== e.sc || lives !== e.lv ||
          speed_level !== e.sp || ball_reset !== br ||
          ball_enable !== be || game_over !== go) begin
        mismatched++;
        $display("FAIL %s: got st=%0d sc=%0d lv=%0d sp=%0d br=%b be=%b go=%b, want st=%0d sc=%0d lv=%0d sp=%0d br=%b be=%b go=%b",
                 nm, state, score, lives, speed_level, ball_reset, ball_enable, game_over,
                 e.st, e.sc, e.lv, e.sp, br, be, go);
      end
    end
  end

  // One clock of stimulus; pulses are cleared after the edge, start is a level.
  task automatic cyc(input logic t, input logic s, input logic h, input logic m);
    @(negedge clk);
    refresh_tick = t; start = s; paddle_hit = h; ball_miss = m;
    @(posedge clk);
    #1;
    refresh_tick = 1'b0; paddle_hit = 1'b0; ball_miss = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, start, 1'b0, 1'b0);
  endtask

  task automatic hits(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, start, 1'b1, 1'b0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 expect_out("reset_state", 3'd0, 16'd0, 2'd3, 4'd1);
    @(negedge clk);
    reset = 1'b1;

    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    expect_out("idle_ignores_events", 3'd0, 16'd0, 2'd3, 4'd1);

    // Game 1: start is held high from here to the reset.
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    expect_out("start_to_serve", 3'd1, 16'd0, 2'd3, 4'd1);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    expect_out("serve_ignores_events", 3'd1, 16'd0, 2'd3, 4'd1);
    ticks(59);
    expect_out("serve_59_ticks", 3'd1, 16'd0, 2'd3, 4'd1);
    ticks(1);
    expect_out("serve_to_play", 3'd2, 16'd0, 2'd3, 4'd1);
    hits(3);
    expect_out("three_hits_level2", 3'd2, 16'd3, 2'd3, 4'd2);
    hits(4);
    expect_out("seven_hits_level3", 3'd2, 16'd7, 2'd3, 4'd3);
    hits(5);
    expect_out("twelve_hits_level5", 3'd2, 16'd12, 2'd3, 4'd5);

    @(posedge clk);
    #2 reset = 1'b0;
    #1 expect_out("async_reset_mid_play", 3'd0, 16'd0, 2'd3, 4'd1);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Game 2
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    expect_out("game2_serve", 3'd1, 16'd0, 2'd3, 4'd1);
    ticks(60);
    expect_out("game2_play", 3'd2, 16'd0, 2'd3, 4'd1);
    hits(5);
    expect_out("five_hits", 3'd2, 16'd5, 2'd3, 4'd2);
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    expect_out("hit_and_miss_same_cycle", 3'd3, 16'd5, 2'd2, 4'd1);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    expect_out("miss_ignores_hit", 3'd3, 16'd5, 2'd2, 4'd1);
    ticks(29);
    expect_out("miss_29_ticks", 3'd3, 16'd5, 2'd2, 4'd1);
    ticks(1);
    expect_out("miss_to_serve", 3'd1, 16'd5, 2'd2, 4'd1);
    ticks(60);
    hits(32);
    expect_out("level_saturates", 3'd2, 16'd37, 2'd2, 4'd8);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    expect_out("play_ignores_start", 3'd2, 16'd37, 2'd2, 4'd8);
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    expect_out("second_miss", 3'd3, 16'd37, 2'd1, 4'd1);
    ticks(30);
    ticks(60);
    expect_out("back_in_play", 3'd2, 16'd37, 2'd1, 4'd1);
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    expect_out("third_miss", 3'd3, 16'd37, 2'd0, 4'd1);
    ticks(30);
    expect_out("game_over", 3'd4, 16'd37, 2'd0, 4'd1);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    expect_out("over_holds", 3'd4, 16'd37, 2'd0, 4'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    expect_out("restart_from_over", 3'd1, 16'd0, 2'd3, 4'd1);

    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
Game-sequencing controller for the pong pixel/ball datapath. It runs the match through idle, serve, play, miss and game-over phases, and holds the score, lives and speed level. It drives ball-reset/ball-enable and a speed level into the ball/paddle datapath. It consumes per-frame ticks and hit/miss event pulses from that datapath.

Parameters:
LIVES, 3, lives loaded at game start (1..3)
SERVE_FRAMES, 60, refresh ticks spent in SERVE before play (1..255)
MISS_FRAMES, 30, refresh ticks spent in MISS before next serve/over (1..255)
HITS_PER_LEVEL, 3, paddle hits per speed-level increment (1..15)
MAX_LEVEL, 8, speed_level saturation value (1..15)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
refresh_tick  input  1  one-clk pulse per frame, from datapath
start  input  1  start button, already synchronised; rising edge detected internally
paddle_hit  input  1  one-clk pulse, ball struck paddle
ball_miss  input  1  one-clk pulse, ball passed paddle edge
ball_reset  output  1  hold ball/paddle at home position
ball_enable  output  1  allow ball motion on refresh ticks
speed_level  output  4  ball speed multiplier, 1..MAX_LEVEL
score  output  16  paddle hits this game
lives  output  2  remaining lives
game_over  output  1  high in OVER
state  output  3  IDLE=0, SERVE=1, PLAY=2, MISS=3, OVER=4 (debug)

Behaviour:
- All outputs are registered. Events take effect on the clk edge where they are sampled, so outputs show them one cycle later.
- Reset (reset=0, async) puts the block in the following state:
  - state=IDLE, score=0, lives=LIVES, speed_level=1
  - ball_reset=1, ball_enable=0, game_over=0
  - frame counter=0, hit counter=0, start edge register=0
- start_rise = start & ~start_d. start_d is a flop that resets to 0.
- IDLE: ball_reset=1, ball_enable=0.
  - On start_rise: go to SERVE, score=0, lives=LIVES, speed_level=1, hit counter=0, frame counter=SERVE_FRAMES.
- SERVE: ball_reset=1, ball_enable=0.
  - Each refresh_tick decrements the frame counter.
  - The tick that takes the counter 1->0 moves the block to PLAY.
- PLAY: ball_reset=0, ball_enable=1.
  - paddle_hit: score+1, saturating at 16'hFFFF. Hit counter+1.
  - When the hit counter reaches HITS_PER_LEVEL, clear it and increment speed_level, saturating at MAX_LEVEL. At saturation the hit counter still wraps.
  - ball_miss: go to MISS, lives-1, frame counter=MISS_FRAMES, speed_level=1, hit counter=0.
  - paddle_hit and ball_miss in the same cycle: the miss wins and the hit is discarded (score unchanged).
- MISS: ball_reset=1, ball_enable=0.
  - Count MISS_FRAMES refresh ticks, the same way as SERVE.
  - On expiry: if lives==0, go to OVER. Otherwise go to SERVE with frame counter=SERVE_FRAMES.
- OVER: game_over=1, ball_reset=1, ball_enable=0. score and lives are held.
  - On start_rise: same action as from IDLE (new game). game_over drops the next cycle.
- Ignored inputs:
  - start_rise in SERVE, PLAY or MISS.
  - paddle_hit and ball_miss outside PLAY.
  - refresh_tick in IDLE, PLAY and OVER (the frame counter is held).
- lives never underflows. MISS is entered only from PLAY, and PLAY is reached only with lives>=1.
- Any illegal state encoding goes to IDLE on the next clk.
- Reset asserted mid-game returns to IDLE with the reset values above, regardless of any pending tick or event.

Test Plan:
- Reset, then start pulse: state 0->1 one clk after the rise; score=0, lives=3, ball_reset=1. After 60 refresh_ticks, state=2, ball_enable=1, ball_reset=0.
- PLAY with 7 paddle_hit pulses: score=7, speed_level=3 (increments after the 3rd and 6th hits). 30 more hits: speed_level stops at 8 and score=37.
- Same-cycle paddle_hit+ball_miss at score=5, lives=3: state=MISS, score stays 5, lives=2, speed_level=1. After 30 ticks, state=SERVE.
- Three misses from a fresh game: after the 3rd MISS expires, state=OVER, game_over=1, lives=0. Next start rise: state=SERVE, lives=3, score=0, game_over=0.
- Drive paddle_hit and ball_miss in IDLE, SERVE and OVER, and start during PLAY: score, lives and state are unchanged. Holding start high across states produces only one start_rise.
- Assert reset low mid-PLAY with score=12: immediately state=IDLE, score=0, lives=3, speed_level=1, ball_reset=1, asynchronous to clk.
